ts_bus_arbiter: RTL
===================

TS_BUS_ARBITER -- requirements
Module: ts_bus_arbiter

Interface
Parameters:
REQ-001 N_SLAVES, 4, number of slave ports (1..16) the block SHALL serve.
REQ-002 ADDR_W, 8, address width in bits.
REQ-003 DATA_W, 8, data width in bits.
REQ-004 SEL_LSB, 6, lowest address bit of the slave-index field; the field SHALL be addr[ADDR_W-1:SEL_LSB].
REQ-005 TIMEOUT, 8, maximum number of cycles the block SHALL wait for a slave ack (>=1).

Ports:
REQ-006 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 m_req  in  1  master request strobe, one cycle.
REQ-009 m_we  in  1  1 = write, 0 = read.
REQ-010 m_addr  in  ADDR_W  master address.
REQ-011 m_wdata  in  DATA_W  write data.
REQ-012 m_busy  out  1  high while a transfer is in progress.
REQ-013 m_ack  out  1  one-cycle completion pulse.
REQ-014 m_err  out  1  valid with m_ack: unmapped address or timeout.
REQ-015 m_rdata  out  DATA_W  read data, valid with m_ack.
REQ-016 s_sel  out  N_SLAVES  one-hot slave select.
REQ-017 s_we, s_addr, s_wdata  out  1/ADDR_W/DATA_W  registered copies of the accepted m_we/m_addr/m_wdata.
REQ-018 s_ack  in  N_SLAVES  per-slave acknowledge.
REQ-019 s_rdata  in  N_SLAVES*DATA_W  packed slave read data; slave i SHALL occupy bits [i*DATA_W +: DATA_W].

Function
REQ-020 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-021 IDLE: m_req=1 SHALL latch m_we/m_addr/m_wdata and decode idx = slave-index field.
REQ-022 If idx < N_SLAVES, the next cycle SHALL be WAIT with s_sel[idx]=1 and all other s_sel bits 0.
REQ-023 If idx >= N_SLAVES, the next cycle SHALL be RESP with m_err=1, m_rdata=0 and s_sel all 0.
REQ-024 WAIT: s_ack[idx]=1 SHALL capture s_rdata slice idx (reads; 0 for writes) into m_rdata, drop s_sel in the next cycle and go to RESP with m_err=0.
REQ-025 WAIT: s_ack bits of non-selected slaves SHALL be ignored.
REQ-026 WAIT: a counter SHALL count cycles with s_sel high; if no ack arrives in TIMEOUT cycles, the block SHALL go to RESP with m_err=1 and m_rdata=0.
REQ-027 An ack arriving in the same cycle the count reaches TIMEOUT SHALL win, giving m_err=0.
REQ-028 RESP: m_ack SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-029 m_busy SHALL be 1 in WAIT and RESP; m_req in those states SHALL be ignored, with no queueing.
REQ-030 Latency: a mapped access with ack in the first WAIT cycle SHALL give m_ack 2 cycles after the m_req cycle; an unmapped access SHALL give m_ack 1 cycle after.
REQ-031 m_rdata and m_err SHALL hold their values until the next RESP.
REQ-032 The counter SHALL be $clog2(TIMEOUT+1) bits wide and SHALL NOT wrap.

Reset
REQ-033 rst=1 SHALL, at the next clock edge, set state=IDLE, s_sel=0, m_busy=0, m_ack=0, m_err=0, m_rdata=0, s_we=0, s_addr=0, s_wdata=0 and counter=0.
REQ-034 Reset asserted mid-transfer SHALL abort the transfer, with no m_ack issued; m_req during reset SHALL be ignored.

Structure
REQ-035 Package ts_bus_pkg SHALL hold the state enum typedef (IDLE/WAIT/RESP) and a function that converts an index to a one-hot vector.
REQ-036 Address decode SHALL be the sub-module ts_addr_decode (combinational: addr in; idx and hit out), parametrised by ADDR_W, SEL_LSB and N_SLAVES.

Verification (N_SLAVES=4, ADDR_W=8, SEL_LSB=6, DATA_W=8, TIMEOUT=8)
REQ-037 Read addr 0x50 with slave 1 acking in its first WAIT cycle with 0xA5 -> s_sel=0b0010, m_ack 2 cycles after m_req, m_rdata=0xA5, m_err=0.
REQ-038 Write addr 0xC3, data 0x3C, slave 3 acking after 3 cycles -> s_we=1, s_wdata=0x3C, s_sel=0b1000 for 3 cycles, then m_ack=1 with m_err=0.
REQ-039 N_SLAVES=3 build, addr 0xC0 -> s_sel stays 0, m_ack 1 cycle after m_req, m_err=1, m_rdata=0.
REQ-040 Slave 0 never acks while slave 2 acks spuriously -> s_sel=0b0001 for exactly 8 cycles, then m_ack with m_err=1.
REQ-041 Second m_req while m_busy=1 -> ignored; exactly one m_ack issued; rst in WAIT -> s_sel=0 and m_busy=0 next cycle, no m_ack issued.

Source files
------------

// File: rtl/ts_bus_pkg.sv
// Shared types and helpers for the single-master bus arbiter.
package ts_bus_pkg;

  // Upper bound on the number of slave ports the arbiter can serve.
  localparam int MAX_SLAVES = 16;

  // Transfer state: idle, waiting for a slave ack, responding to the master.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Index to one-hot over the full slave range; callers slice what they need.
  function automatic logic [MAX_SLAVES-1:0] idx_to_onehot(input logic [31:0] idx);
    logic [MAX_SLAVES-1:0] vec;
    vec = '0;
    for (int unsigned i = 0; i < MAX_SLAVES; i++) begin
      vec[i] = (idx == i);
    end
    return vec;
  endfunction

endpackage

// File: rtl/ts_addr_decode.sv
// Combinational slave-index decode from the upper address field.
module ts_addr_decode #(
  parameter int ADDR_W   = 8,
  parameter int SEL_LSB  = 6,
  parameter int N_SLAVES = 4
) (
  input  logic [ADDR_W-1:0]         addr_i,
  output logic [ADDR_W-SEL_LSB-1:0] idx_o,
  output logic                      hit_o
);

  // The index field is everything above SEL_LSB; a hit means a slave exists there.
  assign idx_o = addr_i[ADDR_W-1:SEL_LSB];
  assign hit_o = (32'(idx_o) < 32'(N_SLAVES));

endmodule

// File: rtl/ts_bus_arbiter.sv
// Single-master to N-slave bus bridge with address decode and ack timeout.
module ts_bus_arbiter
  import ts_bus_pkg::*;
#(
  parameter int N_SLAVES = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int SEL_LSB  = 6,
  parameter int TIMEOUT  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       m_req,
  input  logic                       m_we,
  input  logic [ADDR_W-1:0]          m_addr,
  input  logic [DATA_W-1:0]          m_wdata,
  output logic                       m_busy,
  output logic                       m_ack,
  output logic                       m_err,
  output logic [DATA_W-1:0]          m_rdata,
  output logic [N_SLAVES-1:0]        s_sel,
  output logic                       s_we,
  output logic [ADDR_W-1:0]          s_addr,
  output logic [DATA_W-1:0]          s_wdata,
  input  logic [N_SLAVES-1:0]        s_ack,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata
);

  localparam int IDX_W = ADDR_W - SEL_LSB;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_SLAVES-1:0] s_sel_q, s_sel_d;
  logic                s_we_q, s_we_d;
  logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
  logic [DATA_W-1:0]   s_wdata_q, s_wdata_d;
  logic                m_err_q, m_err_d;
  logic [DATA_W-1:0]   m_rdata_q, m_rdata_d;

  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_hit;
  logic [MAX_SLAVES-1:0] sel_full;
  logic                  sel_full_unused;
  logic                  ack_hit;
  logic [DATA_W-1:0]     rd_mux;
  logic [N_SLAVES-1:0][DATA_W-1:0] rd_masked;

  ts_addr_decode #(
    .ADDR_W  (ADDR_W),
    .SEL_LSB (SEL_LSB),
    .N_SLAVES(N_SLAVES)
  ) u_decode (
    .addr_i(m_addr),
    .idx_o (dec_idx),
    .hit_o (dec_hit)
  );

  assign sel_full        = idx_to_onehot(32'(dec_idx));
  assign sel_full_unused = ^sel_full;

  // Only the currently selected slave may complete the transfer.
  assign ack_hit = |(s_sel_q & s_ack);

  // Mask each slave's read lane with its select so the OR below is a clean mux.
  generate
    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_rd_lane
      assign rd_masked[gi] = s_sel_q[gi] ? s_rdata[gi*DATA_W +: DATA_W] : '0;
    end
  endgenerate

  // OR-reduce the masked lanes into the selected slave's read data.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      rd_mux = rd_mux | rd_masked[i];
    end
  end

  // Next-state logic for the transfer FSM and its datapath registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    s_sel_d   = s_sel_q;
    s_we_d    = s_we_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    m_err_d   = m_err_q;
    m_rdata_d = m_rdata_q;
    case (state_q)
      IDLE: begin
        if (m_req) begin
          s_we_d    = m_we;
          s_addr_d  = m_addr;
          s_wdata_d = m_wdata;
          cnt_d     = '0;
          if (dec_hit) begin
            state_d = WAIT;
            s_sel_d = sel_full[N_SLAVES-1:0];
          end else begin
            state_d   = RESP;
            s_sel_d   = '0;
            m_err_d   = 1'b1;
            m_rdata_d = '0;
          end
        end
      end
      WAIT: begin
        // An ack in the final allowed cycle still beats the timeout.
        if (ack_hit) begin
          state_d   = RESP;
          s_sel_d   = '0;
          m_err_d   = 1'b0;
          m_rdata_d = s_we_q ? '0 : rd_mux;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = RESP;
          s_sel_d   = '0;
          m_err_d   = 1'b1;
          m_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        s_sel_d = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      s_sel_q   <= '0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      m_err_q   <= 1'b0;
      m_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s_sel_q   <= s_sel_d;
      s_we_q    <= s_we_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      m_err_q   <= m_err_d;
      m_rdata_q <= m_rdata_d;
    end
  end

  assign m_busy  = (state_q != IDLE);
  assign m_ack   = (state_q == RESP);
  assign m_err   = m_err_q;
  assign m_rdata = m_rdata_q;
  assign s_sel   = s_sel_q;
  assign s_we    = s_we_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;

endmodule
